processor_bip3: RTL and testbench
=================================

PROCESSOR_BIP3 -- requirements
Module: processor_bip3

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, meaning accumulator and data-memory word width (8..32).
REQ-002 The block SHALL have parameter ADDR_W, default 11, meaning instruction operand, PC and memory address width; instruction width is 5+ADDR_W.
REQ-003 The block SHALL have port CLOCK_i  input  1  meaning the single system clock, rising-edge active.
REQ-004 The block SHALL have port RESET_i  input  1  meaning asynchronous active-low reset.
REQ-005 The block SHALL have port IM_REQ_o  output  1  meaning instruction fetch request, held until acknowledged.
REQ-006 The block SHALL have port IM_ACK_i  input  1  meaning instruction word valid on DATA_im_i this cycle.
REQ-007 The block SHALL have port ADDR_im_o  output  ADDR_W  meaning instruction address (PC).
REQ-008 The block SHALL have port DATA_im_i  input  5+ADDR_W  meaning instruction word, opcode in top 5 bits, operand below.
REQ-009 The block SHALL have port DM_REQ_o  output  1  meaning data-memory request, held until acknowledged.
REQ-010 The block SHALL have port DM_ACK_i  input  1  meaning data access complete; read data valid this cycle.
REQ-011 The block SHALL have port WRRAM_o  output  1  meaning write strobe, high only together with DM_REQ_o for STO.
REQ-012 The block SHALL have port ADDR_dm_o  output  ADDR_W  meaning data address (operand field).
REQ-013 The block SHALL have port IN_DATA_o  output  DATA_W  meaning store data (ACC).
REQ-014 The block SHALL have port OUT_DATA_i  input  DATA_W  meaning load data.
REQ-015 The block SHALL have port HALT_o  output  1  meaning core stopped on HLT.

Function
REQ-016 Opcodes SHALL be: 00000 HLT, 00001 STO, 00010 LD, 00011 LDI, 00100 ADD, 00101 ADDI, 00110 SUB, 00111 SUBI, 01000 BEQ, 01001 BNE, 01010 BGT, 01011 BGE, 01100 BLT, 01101 BLE, 01110 JMP; any other opcode is a NOP.
REQ-017 FSM states SHALL be FETCH, EXEC, MEM, HALT; FETCH->EXEC on IM_ACK_i; EXEC->MEM for STO/LD/ADD/SUB; EXEC->HALT for HLT; EXEC->FETCH otherwise; MEM->FETCH on DM_ACK_i.
REQ-018 IM_REQ_o SHALL be high in every FETCH cycle; IR latches DATA_im_i on the cycle IM_ACK_i is high; IM_ACK_i outside FETCH is ignored.
REQ-019 DM_REQ_o SHALL be high in every MEM cycle with ADDR_dm_o, WRRAM_o, IN_DATA_o stable; DM_ACK_i outside MEM is ignored.
REQ-020 Immediate operands (LDI/ADDI/SUBI) SHALL be sign-extended or truncated from ADDR_W to DATA_W.
REQ-021 ADD/ADDI/SUB/SUBI SHALL update ACC modulo 2^DATA_W and set Z=(result==0), N=result[DATA_W-1]; LD/LDI/STO leave Z,N unchanged.
REQ-022 Branches SHALL test registered Z,N: BEQ Z; BNE !Z; BGT !Z&!N; BGE !N; BLT N; BLE Z|N; JMP always; taken -> PC=operand, else PC+1.
REQ-023 PC SHALL increment modulo 2^ADDR_W in the EXEC (non-memory) or MEM completion cycle; max address wraps to 0.
REQ-024 Minimum latency SHALL be 2 cycles for non-memory instructions and 3 for memory instructions with zero-wait acks; each wait cycle adds one.
REQ-025 In HALT, HALT_o=1, no requests issue, all registers hold until reset.

Reset
REQ-026 On RESET_i low, asynchronously: state=FETCH, PC=0, IR=0, ACC=0, Z=0, N=0, HALT_o=0, DM_REQ_o=0, WRRAM_o=0; IM_REQ_o rises in the first cycle after release.
REQ-027 Reset mid-request SHALL abort the transaction with no ACC/PC update; a late ack after release is ignored unless in matching state.

Structure
REQ-028 Opcode constants, state encoding and default widths SHALL live in package bip_pkg.
REQ-029 Arithmetic and flag generation SHALL be a sub-module bip_alu (ADD/SUB, DATA_W-parametrised, combinational).

Verification
REQ-030 LDI 5; ADDI -5; BEQ 0x010 with zero-wait acks -> ACC=0, Z=1, PC=0x010 after 6 cycles.
REQ-031 LDI 0x7; STO 0x020 with DM_ACK_i delayed 3 cycles -> DM_REQ_o/WRRAM_o high 4 cycles, IN_DATA_o=7, ADDR_dm_o=0x020.
REQ-032 LDI 1; SUBI 2 (DATA_W=16) -> ACC=0xFFFF, N=1, Z=0; BLT taken, BGE not taken.
REQ-033 JMP 0x7FF then NOP at 0x7FF (ADDR_W=11) -> next ADDR_im_o=0x000.
REQ-034 RESET_i low while DM_REQ_o pending LD -> ACC=0, PC=0, DM_REQ_o=0 immediately; after release fetch from address 0.
REQ-035 HLT -> HALT_o=1, IM_REQ_o stays 0 for 20 cycles, ACC unchanged.

Source files
------------

// File: rtl/bip_pkg.sv
// Shared constants for the BIP3 accumulator core: default widths, opcodes, FSM states.
package bip_pkg;

   localparam int unsigned DATA_W_DEF = 16;
   localparam int unsigned ADDR_W_DEF = 11;
   localparam int unsigned OPC_W      = 5;

   typedef enum logic [OPC_W-1:0] {
      OP_HLT  = 5'b00000,
      OP_STO  = 5'b00001,
      OP_LD   = 5'b00010,
      OP_LDI  = 5'b00011,
      OP_ADD  = 5'b00100,
      OP_ADDI = 5'b00101,
      OP_SUB  = 5'b00110,
      OP_SUBI = 5'b00111,
      OP_BEQ  = 5'b01000,
      OP_BNE  = 5'b01001,
      OP_BGT  = 5'b01010,
      OP_BGE  = 5'b01011,
      OP_BLT  = 5'b01100,
      OP_BLE  = 5'b01101,
      OP_JMP  = 5'b01110
   } opcode_t;

   // One-hot so each request strobe maps onto a single state flop.
   typedef enum logic [3:0] {
      ST_FETCH = 4'b0001,
      ST_EXEC  = 4'b0010,
      ST_MEM   = 4'b0100,
      ST_HALT  = 4'b1000
   } state_t;

endpackage

// File: rtl/processor_bip3_if.sv
// Instruction and data memory request/ack bus between the BIP3 core and its memories.
interface processor_bip3_if
   import bip_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned ADDR_W = ADDR_W_DEF
);
   logic                    im_req;
   logic                    im_ack;
   logic [ADDR_W-1:0]       im_addr;
   logic [OPC_W+ADDR_W-1:0] im_data;
   logic                    dm_req;
   logic                    dm_ack;
   logic                    wr;
   logic [ADDR_W-1:0]       dm_addr;
   logic [DATA_W-1:0]       wdata;
   logic [DATA_W-1:0]       rdata;

   modport master (
      output im_req, im_addr, dm_req, wr, dm_addr, wdata,
      input  im_ack, im_data, dm_ack, rdata
   );

   modport slave (
      input  im_req, im_addr, dm_req, wr, dm_addr, wdata,
      output im_ack, im_data, dm_ack, rdata
   );
endinterface

// File: rtl/bip_alu.sv
// Combinational add/subtract with zero and negative flag generation.
module bip_alu #(
   parameter int unsigned DATA_W = 16
) (
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic              sub,
   output logic [DATA_W-1:0] y,
   output logic              z,
   output logic              n
);
   always_comb begin
      y = sub ? (a - b) : (a + b);
      z = (y == '0);
      n = y[DATA_W-1];
   end
endmodule

// File: rtl/processor_bip3_core.sv
// BIP3 fetch/execute/memory sequencer: PC, IR, ACC and Z/N flags.
module processor_bip3_core
   import bip_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned ADDR_W = ADDR_W_DEF
) (
   input  logic                clk,
   input  logic                rst_n,
   processor_bip3_if.master    bus,
   output logic                halt
);
   state_t                  state;
   logic [ADDR_W-1:0]       pc;
   logic [OPC_W+ADDR_W-1:0] ir;
   logic [DATA_W-1:0]       acc;
   logic                    z;
   logic                    n;
   logic                    dm_req;
   logic                    wr;

   logic [OPC_W-1:0]        opc;
   logic [ADDR_W-1:0]       operand;
   logic [DATA_W-1:0]       imm;
   logic [ADDR_W-1:0]       pc_inc;
   logic [DATA_W-1:0]       alu_b;
   logic [DATA_W-1:0]       alu_y;
   logic                    alu_sub;
   logic                    alu_z;
   logic                    alu_n;
   logic                    taken;

   assign opc     = ir[OPC_W+ADDR_W-1 -: OPC_W];
   assign operand = ir[ADDR_W-1:0];
   assign imm     = DATA_W'($signed(operand));
   assign pc_inc  = pc + ADDR_W'(1);
   assign alu_b   = (state == ST_MEM) ? bus.rdata : imm;
   assign alu_sub = (opc == OP_SUB) || (opc == OP_SUBI);

   bip_alu #(.DATA_W(DATA_W)) u_alu (
      .a   (acc),
      .b   (alu_b),
      .sub (alu_sub),
      .y   (alu_y),
      .z   (alu_z),
      .n   (alu_n)
   );

   // Branch decision from the registered flags.
   always_comb begin
      taken = 1'b0;
      case (opc)
         OP_BEQ:  taken = z;
         OP_BNE:  taken = !z;
         OP_BGT:  taken = !z && !n;
         OP_BGE:  taken = !n;
         OP_BLT:  taken = n;
         OP_BLE:  taken = z || n;
         OP_JMP:  taken = 1'b1;
         default: taken = 1'b0;
      endcase
   end

   // Fetch request is gated by reset so it first appears once reset is released.
   assign bus.im_req  = (state == ST_FETCH) && rst_n;
   assign bus.im_addr = pc;
   assign bus.dm_req  = dm_req;
   assign bus.wr      = wr;
   assign bus.dm_addr = operand;
   assign bus.wdata   = acc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= ST_FETCH;
         pc     <= '0;
         ir     <= '0;
         acc    <= '0;
         z      <= 1'b0;
         n      <= 1'b0;
         dm_req <= 1'b0;
         wr     <= 1'b0;
         halt   <= 1'b0;
      end else begin
         case (state)
            ST_FETCH: begin
               if (bus.im_ack) begin
                  ir    <= bus.im_data;
                  state <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               state <= ST_FETCH;
               case (opc)
                  OP_HLT: begin
                     state <= ST_HALT;
                     halt  <= 1'b1;
                  end
                  OP_STO, OP_LD, OP_ADD, OP_SUB: begin
                     state  <= ST_MEM;
                     dm_req <= 1'b1;
                     wr     <= (opc == OP_STO);
                  end
                  OP_LDI: begin
                     acc <= imm;
                     pc  <= pc_inc;
                  end
                  OP_ADDI, OP_SUBI: begin
                     acc <= alu_y;
                     z   <= alu_z;
                     n   <= alu_n;
                     pc  <= pc_inc;
                  end
                  default: pc <= taken ? operand : pc_inc;
               endcase
            end
            ST_MEM: begin
               if (bus.dm_ack) begin
                  if (opc == OP_LD) begin
                     acc <= bus.rdata;
                  end else if (opc != OP_STO) begin
                     acc <= alu_y;
                     z   <= alu_z;
                     n   <= alu_n;
                  end
                  pc     <= pc_inc;
                  dm_req <= 1'b0;
                  wr     <= 1'b0;
                  state  <= ST_FETCH;
               end
            end
            ST_HALT: begin
            end
            default: state <= ST_FETCH;
         endcase
      end
   end
endmodule

// File: rtl/processor_bip3.sv
// BIP3 accumulator processor top: maps the pin-level memory ports onto the core bus.
module processor_bip3
   import bip_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned ADDR_W = ADDR_W_DEF
) (
   input  logic                    CLOCK_i,
   input  logic                    RESET_i,
   output logic                    IM_REQ_o,
   input  logic                    IM_ACK_i,
   output logic [ADDR_W-1:0]       ADDR_im_o,
   input  logic [OPC_W+ADDR_W-1:0] DATA_im_i,
   output logic                    DM_REQ_o,
   input  logic                    DM_ACK_i,
   output logic                    WRRAM_o,
   output logic [ADDR_W-1:0]       ADDR_dm_o,
   output logic [DATA_W-1:0]       IN_DATA_o,
   input  logic [DATA_W-1:0]       OUT_DATA_i,
   output logic                    HALT_o
);
   processor_bip3_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

   assign bus.im_ack  = IM_ACK_i;
   assign bus.im_data = DATA_im_i;
   assign bus.dm_ack  = DM_ACK_i;
   assign bus.rdata   = OUT_DATA_i;

   assign IM_REQ_o  = bus.im_req;
   assign ADDR_im_o = bus.im_addr;
   assign DM_REQ_o  = bus.dm_req;
   assign WRRAM_o   = bus.wr;
   assign ADDR_dm_o = bus.dm_addr;
   assign IN_DATA_o = bus.wdata;

   processor_bip3_core #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_core (
      .clk   (CLOCK_i),
      .rst_n (RESET_i),
      .bus   (bus.master),
      .halt  (HALT_o)
   );
endmodule

// File: tb/tb_processor_bip3.sv
// Directed bench for processor_bip3 with behavioural instruction/data memories.
module tb_processor_bip3;
   import bip_pkg::*;

   logic clk;
   logic rst_n;
   logic halt;
   int   checks;
   int   errors;
   int   im_wait;
   int   dm_wait;
   int   im_cnt;
   int   dm_cnt;

   logic [15:0] imem [0:2047];
   logic [15:0] dmem [0:2047];

   processor_bip3_if #(.DATA_W(16), .ADDR_W(11)) bus ();

   processor_bip3 #(.DATA_W(16), .ADDR_W(11)) dut (
      .CLOCK_i    (clk),
      .RESET_i    (rst_n),
      .IM_REQ_o   (bus.im_req),
      .IM_ACK_i   (bus.im_ack),
      .ADDR_im_o  (bus.im_addr),
      .DATA_im_i  (bus.im_data),
      .DM_REQ_o   (bus.dm_req),
      .DM_ACK_i   (bus.dm_ack),
      .WRRAM_o    (bus.wr),
      .ADDR_dm_o  (bus.dm_addr),
      .IN_DATA_o  (bus.wdata),
      .OUT_DATA_i (bus.rdata),
      .HALT_o     (halt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Memory responders: ack after im_wait/dm_wait idle request cycles.
   initial begin
      bus.im_ack = 1'b0; bus.im_data = '0; bus.dm_ack = 1'b0; bus.rdata = '0;
      im_cnt = 0; dm_cnt = 0;
      forever begin
         @(negedge clk);
         bus.im_ack = 1'b0;
         bus.dm_ack = 1'b0;
         if (bus.im_req === 1'b1) begin
            if (im_cnt >= im_wait) begin
               bus.im_ack  = 1'b1;
               bus.im_data = imem[bus.im_addr];
               im_cnt = 0;
            end else im_cnt++;
         end else im_cnt = 0;
         if (bus.dm_req === 1'b1) begin
            if (dm_cnt >= dm_wait) begin
               bus.dm_ack = 1'b1;
               if (bus.wr === 1'b1) dmem[bus.dm_addr] = bus.wdata;
               bus.rdata = dmem[bus.dm_addr];
               dm_cnt = 0;
            end else dm_cnt++;
         end else dm_cnt = 0;
      end
   end

   function automatic logic [15:0] ins(input logic [4:0] op, input logic [10:0] a);
      return {op, a};
   endfunction

   task automatic prog_clear();
      for (int i = 0; i < 2048; i++) begin
         imem[i] = 16'h0000;
         dmem[i] = 16'h0000;
      end
      im_wait = 0;
      dm_wait = 0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic test_reset();
      prog_clear();
      imem[0] = ins(OP_LDI, 11'd1);
      rst_n = 1'b0;
      @(posedge clk); #2;
      checks++; if (bus.im_req !== 1'b0) begin errors++; $display("FAIL reset_im_req got %0h exp 0", bus.im_req); end
      checks++; if (bus.dm_req !== 1'b0 || bus.wr !== 1'b0) begin errors++; $display("FAIL reset_dm got req %0h wr %0h exp 0 0", bus.dm_req, bus.wr); end
      checks++; if (halt !== 1'b0) begin errors++; $display("FAIL reset_halt got %0h exp 0", halt); end
      checks++; if (bus.im_addr !== 11'h000 || bus.wdata !== 16'h0000) begin errors++; $display("FAIL reset_pc_acc got pc %0h acc %0h exp 0 0", bus.im_addr, bus.wdata); end
      rst_n = 1'b1;
      #1;
      checks++; if (bus.im_req !== 1'b1) begin errors++; $display("FAIL reset_release_im_req got %0h exp 1", bus.im_req); end
   endtask

   task automatic test_branch_zero();
      prog_clear();
      imem[0] = ins(OP_LDI, 11'd5);
      imem[1] = ins(OP_ADDI, 11'h7FB);
      imem[2] = ins(OP_BEQ, 11'h010);
      do_reset();
      tick(2);
      checks++; if (bus.wdata !== 16'd5 || bus.im_addr !== 11'd1) begin errors++; $display("FAIL ldi got acc %0h pc %0h exp 5 1", bus.wdata, bus.im_addr); end
      tick(2);
      checks++; if (bus.wdata !== 16'd0 || bus.im_addr !== 11'd2) begin errors++; $display("FAIL addi_neg got acc %0h pc %0h exp 0 2", bus.wdata, bus.im_addr); end
      tick(1);
      checks++; if (bus.im_addr !== 11'd2) begin errors++; $display("FAIL beq_early got pc %0h exp 2", bus.im_addr); end
      tick(1);
      checks++; if (bus.im_addr !== 11'h010) begin errors++; $display("FAIL beq_taken got pc %0h exp 10", bus.im_addr); end
      tick(2);
      checks++; if (halt !== 1'b1) begin errors++; $display("FAIL halt_at_target got %0h exp 1", halt); end
   endtask

   task automatic test_store_wait();
      int n_req, n_wr, n_bad;
      prog_clear();
      imem[0] = ins(OP_LDI, 11'd7);
      imem[1] = ins(OP_STO, 11'h020);
      dm_wait = 3;
      n_req = 0; n_wr = 0; n_bad = 0;
      do_reset();
      for (int i = 0; i < 20; i++) begin
         tick(1);
         if (bus.dm_req === 1'b1) n_req++;
         if (bus.wr === 1'b1) n_wr++;
         if (bus.dm_req === 1'b1 && (bus.wdata !== 16'd7 || bus.dm_addr !== 11'h020)) n_bad++;
         if (bus.wr === 1'b1 && bus.dm_req !== 1'b1) n_bad++;
      end
      checks++; if (n_req != 4) begin errors++; $display("FAIL sto_req_cycles got %0d exp 4", n_req); end
      checks++; if (n_wr != 4) begin errors++; $display("FAIL sto_wr_cycles got %0d exp 4", n_wr); end
      checks++; if (n_bad != 0) begin errors++; $display("FAIL sto_stable got %0d bad cycles exp 0", n_bad); end
      checks++; if (dmem[11'h020] !== 16'd7) begin errors++; $display("FAIL sto_data got %0h exp 7", dmem[11'h020]); end
      checks++; if (halt !== 1'b1 || bus.im_addr !== 11'd2) begin errors++; $display("FAIL sto_then_hlt got halt %0h pc %0h exp 1 2", halt, bus.im_addr); end
   endtask

   task automatic test_negative();
      prog_clear();
      imem[0] = ins(OP_LDI, 11'd1);
      imem[1] = ins(OP_SUBI, 11'd2);
      imem[2] = ins(OP_BGE, 11'h030);
      imem[3] = ins(OP_BEQ, 11'h030);
      imem[4] = ins(OP_BLT, 11'h040);
      do_reset();
      tick(4);
      checks++; if (bus.wdata !== 16'hFFFF) begin errors++; $display("FAIL subi_wrap got %0h exp ffff", bus.wdata); end
      tick(2);
      checks++; if (bus.im_addr !== 11'd3) begin errors++; $display("FAIL bge_not_taken got pc %0h exp 3", bus.im_addr); end
      tick(2);
      checks++; if (bus.im_addr !== 11'd4) begin errors++; $display("FAIL beq_z0_not_taken got pc %0h exp 4", bus.im_addr); end
      tick(2);
      checks++; if (bus.im_addr !== 11'h040) begin errors++; $display("FAIL blt_taken got pc %0h exp 40", bus.im_addr); end
   endtask

   task automatic test_positive_branches();
      prog_clear();
      imem[0]      = ins(OP_LDI, 11'd3);
      imem[1]      = ins(OP_ADDI, 11'd0);
      imem[2]      = ins(OP_BGT, 11'h060);
      imem[11'h60] = ins(OP_BLE, 11'h070);
      imem[11'h61] = ins(OP_BNE, 11'h080);
      do_reset();
      tick(6);
      checks++; if (bus.im_addr !== 11'h060 || bus.wdata !== 16'd3) begin errors++; $display("FAIL bgt_taken got pc %0h acc %0h exp 60 3", bus.im_addr, bus.wdata); end
      tick(2);
      checks++; if (bus.im_addr !== 11'h061) begin errors++; $display("FAIL ble_not_taken got pc %0h exp 61", bus.im_addr); end
      tick(2);
      checks++; if (bus.im_addr !== 11'h080) begin errors++; $display("FAIL bne_taken got pc %0h exp 80", bus.im_addr); end
   endtask

   task automatic test_pc_wrap();
      prog_clear();
      imem[0]       = ins(OP_JMP, 11'h7FF);
      imem[11'h7FF] = ins(5'b11111, 11'h000);
      do_reset();
      tick(2);
      checks++; if (bus.im_addr !== 11'h7FF) begin errors++; $display("FAIL jmp_max got pc %0h exp 7ff", bus.im_addr); end
      tick(2);
      checks++; if (bus.im_addr !== 11'h000 || bus.im_req !== 1'b1) begin errors++; $display("FAIL pc_wrap got pc %0h req %0h exp 0 1", bus.im_addr, bus.im_req); end
   endtask

   task automatic test_memory_ops();
      prog_clear();
      dmem[5] = 16'h1234;
      dmem[6] = 16'h2468;
      imem[0] = ins(OP_LD, 11'd5);
      imem[1] = ins(OP_ADD, 11'd5);
      imem[2] = ins(OP_SUB, 11'd6);
      imem[3] = ins(OP_BEQ, 11'h050);
      do_reset();
      tick(3);
      checks++; if (bus.wdata !== 16'h1234 || bus.im_addr !== 11'd1) begin errors++; $display("FAIL ld got acc %0h pc %0h exp 1234 1", bus.wdata, bus.im_addr); end
      tick(3);
      checks++; if (bus.wdata !== 16'h2468) begin errors++; $display("FAIL add_mem got %0h exp 2468", bus.wdata); end
      tick(3);
      checks++; if (bus.wdata !== 16'h0000 || bus.im_addr !== 11'd3) begin errors++; $display("FAIL sub_mem got acc %0h pc %0h exp 0 3", bus.wdata, bus.im_addr); end
      tick(2);
      checks++; if (bus.im_addr !== 11'h050) begin errors++; $display("FAIL beq_after_sub got pc %0h exp 50", bus.im_addr); end
   endtask

   task automatic test_fetch_wait();
      prog_clear();
      imem[0] = ins(OP_LDI, 11'h123);
      im_wait = 2;
      do_reset();
      tick(3);
      checks++; if (bus.wdata !== 16'h0000) begin errors++; $display("FAIL fetch_wait_early got %0h exp 0", bus.wdata); end
      tick(1);
      checks++; if (bus.wdata !== 16'h0123 || bus.im_addr !== 11'd1) begin errors++; $display("FAIL fetch_wait_done got acc %0h pc %0h exp 123 1", bus.wdata, bus.im_addr); end
   endtask

   task automatic test_reset_mid_load();
      prog_clear();
      dmem[5] = 16'hBEEF;
      imem[0] = ins(OP_LDI, 11'd9);
      imem[1] = ins(OP_LD, 11'd5);
      dm_wait = 50;
      do_reset();
      tick(5);
      checks++; if (bus.dm_req !== 1'b1 || bus.wdata !== 16'd9) begin errors++; $display("FAIL ld_pending got req %0h acc %0h exp 1 9", bus.dm_req, bus.wdata); end
      rst_n = 1'b0;
      #1;
      checks++; if (bus.dm_req !== 1'b0 || bus.wdata !== 16'd0 || bus.im_addr !== 11'd0) begin errors++; $display("FAIL async_abort got req %0h acc %0h pc %0h exp 0 0 0", bus.dm_req, bus.wdata, bus.im_addr); end
      dm_wait = 0;
      @(posedge clk); #2 rst_n = 1'b1;
      #1;
      checks++; if (bus.im_req !== 1'b1 || bus.im_addr !== 11'd0) begin errors++; $display("FAIL refetch_addr got req %0h pc %0h exp 1 0", bus.im_req, bus.im_addr); end
      tick(2);
      checks++; if (bus.wdata !== 16'd9 || bus.im_addr !== 11'd1) begin errors++; $display("FAIL restart_ldi got acc %0h pc %0h exp 9 1", bus.wdata, bus.im_addr); end
   endtask

   task automatic test_halt();
      int n_bad;
      prog_clear();
      imem[0] = ins(OP_LDI, 11'h055);
      imem[1] = ins(OP_HLT, 11'h000);
      n_bad = 0;
      do_reset();
      tick(4);
      checks++; if (halt !== 1'b1 || bus.im_req !== 1'b0) begin errors++; $display("FAIL hlt_enter got halt %0h req %0h exp 1 0", halt, bus.im_req); end
      for (int i = 0; i < 20; i++) begin
         tick(1);
         if (bus.im_req !== 1'b0 || bus.dm_req !== 1'b0 || halt !== 1'b1 || bus.wdata !== 16'h0055) n_bad++;
      end
      checks++; if (n_bad != 0) begin errors++; $display("FAIL hlt_hold got %0d bad cycles exp 0", n_bad); end
      checks++; if (bus.wdata !== 16'h0055) begin errors++; $display("FAIL hlt_acc got %0h exp 55", bus.wdata); end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      im_wait = 0;
      dm_wait = 0;
      test_reset();
      test_branch_zero();
      test_store_wait();
      test_negative();
      test_positive_branches();
      test_pc_wrap();
      test_memory_ops();
      test_fetch_wait();
      test_reset_mid_load();
      test_halt();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
